// File: rtl/tinyjambu_perm_ctrl.sv
// Frame sequencer for the masked TinyJAMBU keyed permutation (fresh handshake, core enable, state shift).
// Optional build macro TJ_PERM_CTRL_ABORT_EN adds abort_i / aborted_o.
//
// state | meaning
// IDLE  | waiting for start_i; round_o holds its last value
// REQ   | requesting a fresh 32-bit word from the PRNG; core and state frozen
// WAIT  | core gadgets clocked for NLFSR_LAT cycles on stable inputs
// SHIFT | one-cycle 32-bit shift of the masked state with the core output
// DONE  | one-cycle completion pulse; round counter cleared
module tinyjambu_perm_ctrl #(
    parameter int NLFSR_LAT    = 2,
    parameter int ROUNDS_SHORT = 20,
    parameter int ROUNDS_LONG  = 32,
    parameter int CNT_W        = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             long_i,
    input  logic             rnd_valid_i,
`ifdef TJ_PERM_CTRL_ABORT_EN
    input  logic             abort_i,
    output logic             aborted_o,
`endif
    output logic             rnd_ready_o,
    output logic             fresh_ld_o,
    output logic             core_en_o,
    output logic             state_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] round_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [2:0]       LAT_LAST   = 3'(NLFSR_LAT - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(ROUNDS_SHORT - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(ROUNDS_LONG - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [2:0]       lat_q, lat_d;
    logic             long_q, long_d;
    logic             abort_req;
    logic             abort_hit;
    logic [CNT_W-1:0] last_round;

`ifdef TJ_PERM_CTRL_ABORT_EN
    logic aborted_q;

    assign abort_req = abort_i;
    assign aborted_o = aborted_q;

    always_ff @(posedge clk) begin
        if (!rst) aborted_q <= 1'b0;
        else      aborted_q <= abort_hit;
    end
`else
    assign abort_req = 1'b0;
`endif

    assign last_round = long_q ? LONG_LAST : SHORT_LAST;
    assign round_o    = round_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            lat_q   <= '0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            lat_q   <= lat_d;
            long_q  <= long_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        lat_d       = lat_q;
        long_d      = long_q;
        abort_hit   = 1'b0;
        rnd_ready_o = 1'b0;
        fresh_ld_o  = 1'b0;
        core_en_o   = 1'b0;
        state_en_o  = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    long_d  = long_i;
                    round_d = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                busy_o = 1'b1;
                // an aborting frame does not consume a PRNG word
                rnd_ready_o = ~abort_req;
                if (abort_req) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (rnd_valid_i) begin
                    fresh_ld_o = 1'b1;
                    lat_d      = LAT_LAST;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                busy_o    = 1'b1;
                core_en_o = 1'b1;
                if (abort_req) begin
                    abort_hit = 1'b1;
                    state_d   = ST_IDLE;
                end else if (lat_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            ST_SHIFT: begin
                busy_o     = 1'b1;
                state_en_o = 1'b1;
                if (round_q == last_round) begin
                    state_d = ST_DONE;
                end else begin
                    round_d = round_q + CNT_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                round_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tinyjambu_perm_ctrl.sv
// Directed bench for tinyjambu_perm_ctrl; abort scenarios are built when TJ_PERM_CTRL_ABORT_EN is defined.
module tb_tinyjambu_perm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_i = 1'b0;
    logic       long_i = 1'b0;
    logic       rnd_valid_i = 1'b1;
    logic       rnd_ready_o, fresh_ld_o, core_en_o, state_en_o, busy_o, done_o;
    logic [5:0] round_o;
`ifdef TJ_PERM_CTRL_ABORT_EN
    logic       abort_i = 1'b0;
    logic       aborted_o;
`endif

    tinyjambu_perm_ctrl #(
        .NLFSR_LAT   (2),
        .ROUNDS_SHORT(20),
        .ROUNDS_LONG (32),
        .CNT_W       (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .long_i     (long_i),
        .rnd_valid_i(rnd_valid_i),
`ifdef TJ_PERM_CTRL_ABORT_EN
        .abort_i    (abort_i),
        .aborted_o  (aborted_o),
`endif
        .rnd_ready_o(rnd_ready_o),
        .fresh_ld_o (fresh_ld_o),
        .core_en_o  (core_en_o),
        .state_en_o (state_en_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .round_o    (round_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rel, n_shift, n_done, n_busy, first_busy, last_busy, done_cyc, n_abort;
    int shift_cyc [64];
    int round_at  [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        rel = 0; n_shift = 0; n_done = 0; n_busy = 0; n_abort = 0;
        first_busy = -1; last_busy = -1; done_cyc = -1;
    endtask

    // advance to the next falling edge and log what the controller did in that cycle
    task automatic tick();
        @(negedge clk);
        rel++;
        if (state_en_o === 1'b1) begin
            if (n_shift < 64) begin
                shift_cyc[n_shift] = rel;
                round_at[n_shift]  = int'(round_o);
            end
            n_shift++;
        end
        if (done_o === 1'b1) begin
            n_done++;
            done_cyc = rel;
        end
        if (busy_o === 1'b1) begin
            n_busy++;
            if (first_busy < 0) first_busy = rel;
            last_busy = rel;
        end
`ifdef TJ_PERM_CTRL_ABORT_EN
        if (aborted_o === 1'b1) n_abort++;
`endif
    endtask

    // start accepted on the next rising edge (cycle 0); long_i flips afterwards and must be ignored
    task automatic launch(input logic lng);
        start_i = 1'b1;
        long_i  = lng;
        clear();
        tick();
        start_i = 1'b0;
        long_i  = ~lng;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) tick();
    endtask

    // frame k shifts at cycle 4*(k+1), plus any stall inserted at or before that frame
    task automatic check_frames(input string tag, input int nfr, input int stall_frame, input int stall);
        for (int k = 0; k < nfr; k++) begin
            chk($sformatf("%s_shift_cyc%0d", tag, k), shift_cyc[k],
                4 * (k + 1) + ((k >= stall_frame) ? stall : 0));
            chk($sformatf("%s_round%0d", tag, k), round_at[k], k);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        repeat (3) tick();
        chk("reset_outs", 32'({rnd_ready_o, fresh_ld_o, core_en_o, state_en_o, busy_o, done_o, round_o}), 0);
        rst = 1'b1;
        tick();
        chk("idle_busy", 32'(busy_o), 0);

        // short permutation
        launch(1'b0);
        wait_done(200);
        tick(); tick();
        chk("short_nshift", n_shift, 20);
        chk("short_done_cyc", done_cyc, 81);
        chk("short_ndone", n_done, 1);
        chk("short_first_busy", first_busy, 1);
        chk("short_last_busy", last_busy, 81);
        chk("short_nbusy", n_busy, 81);
        check_frames("short", 20, 99, 0);
        chk("short_round_after", 32'(round_o), 0);
        chk("short_busy_after", 32'(busy_o), 0);

        // long permutation
        launch(1'b1);
        wait_done(300);
        tick(); tick();
        chk("long_nshift", n_shift, 32);
        chk("long_done_cyc", done_cyc, 129);
        chk("long_nbusy", n_busy, 129);
        check_frames("long", 32, 99, 0);
        chk("long_round_after", 32'(round_o), 0);

        // PRNG stall in frame 3 REQ
        launch(1'b0);
        while (rel < 13) tick();
        chk("stall_round", 32'(round_o), 3);
        chk("stall_ready", 32'(rnd_ready_o), 1);
        rnd_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_core_en", 32'(core_en_o), 0);
            chk("stall_fresh_ld", 32'(fresh_ld_o), 0);
            chk("stall_ready_held", 32'(rnd_ready_o), 1);
            chk("stall_state_en", 32'(state_en_o), 0);
        end
        rnd_valid_i = 1'b1;
        wait_done(200);
        tick();
        chk("stall_nshift", n_shift, 20);
        chk("stall_done_cyc", done_cyc, 86);
        check_frames("stall", 20, 3, 5);

        // reset during WAIT of frame 10
        launch(1'b0);
        while (rel < 42) tick();
        chk("rst_in_wait", 32'(core_en_o), 1);
        chk("rst_in_round", 32'(round_o), 10);
        rst = 1'b0;
        tick();
        chk("rst_outs", 32'({rnd_ready_o, fresh_ld_o, core_en_o, state_en_o, busy_o, done_o, round_o}), 0);
        rst = 1'b1;
        repeat (5) tick();
        chk("rst_nshift", n_shift, 10);
        chk("rst_ndone", n_done, 0);
        chk("rst_busy", 32'(busy_o), 0);
        launch(1'b0);
        wait_done(200);
        tick();
        chk("rst_rerun_nshift", n_shift, 20);
        chk("rst_rerun_done", done_cyc, 81);

        // start during busy and on the done cycle
        launch(1'b0);
        while (rel < 30) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        while (rel < 81) tick();
        chk("retrig_done_now", 32'(done_o), 1);
        chk("retrig_done_cyc", done_cyc, 81);
        chk("retrig_ndone1", n_done, 1);
        long_i  = 1'b0;
        start_i = 1'b1;
        tick();
        chk("retrig_idle_busy", 32'(busy_o), 0);
        chk("retrig_idle_done", 32'(done_o), 0);
        tick();
        chk("retrig_req_busy", 32'(busy_o), 1);
        chk("retrig_req_ready", 32'(rnd_ready_o), 1);
        chk("retrig_req_round", 32'(round_o), 0);
        start_i = 1'b0;
        for (int i = 0; i < 200 && n_done < 2; i++) tick();
        tick();
        chk("retrig_ndone2", n_done, 2);
        chk("retrig_done2_cyc", done_cyc, 163);
        chk("retrig_nshift", n_shift, 40);

`ifdef TJ_PERM_CTRL_ABORT_EN
        // abort in WAIT of frame 5
        launch(1'b0);
        while (rel < 22) tick();
        chk("abw_in_wait", 32'(core_en_o), 1);
        chk("abw_round", 32'(round_o), 5);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("abw_aborted", 32'(aborted_o), 1);
        chk("abw_busy", 32'(busy_o), 0);
        tick();
        chk("abw_aborted_clr", 32'(aborted_o), 0);
        repeat (5) tick();
        chk("abw_nshift", n_shift, 5);
        chk("abw_ndone", n_done, 0);
        chk("abw_nabort", n_abort, 1);

        // abort raised in SHIFT of frame 5, honoured in the next REQ
        launch(1'b0);
        while (rel < 24) tick();
        chk("abs_in_shift", 32'(state_en_o), 1);
        abort_i = 1'b1;
        tick();
        chk("abs_req_busy", 32'(busy_o), 1);
        chk("abs_req_aborted", 32'(aborted_o), 0);
        tick();
        abort_i = 1'b0;
        chk("abs_aborted", 32'(aborted_o), 1);
        chk("abs_busy", 32'(busy_o), 0);
        repeat (5) tick();
        chk("abs_nshift", n_shift, 6);
        chk("abs_ndone", n_done, 0);
        chk("abs_nabort", n_abort, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tinyjambu_perm_ctrl.md
Name: tinyjambu_perm_ctrl

Overview:
Sequencer for the first-order masked TinyJAMBU keyed permutation. It drives the 32-bit-per-frame masked NLFSR feedback core (HPC2 NAND gadgets, registered, fixed latency) through P640 or P1024-equivalent frame counts. It also handles the fresh-randomness handshake with the PRNG, the gadget clock enable, and the 32-bit state-shift strobe. It sits between the mode FSM (start/done) and the shared 128-bit masked state register.

Parameters:
NLFSR_LAT, 2, cycles from stable core inputs/fresh to valid core output; legal range 1..7
ROUNDS_SHORT, 20, 32-bit frames for the short permutation (640 steps)
ROUNDS_LONG, 32, 32-bit frames for the long permutation (1024 steps; 36/40 for 192/256-bit key variants)
CNT_W, 6, round-counter width; must hold ROUNDS_LONG-1

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
start_i  input  1  request a permutation; sampled only in IDLE
long_i  input  1  1 = ROUNDS_LONG, 0 = ROUNDS_SHORT; sampled with start_i
rnd_valid_i  input  1  PRNG has 32 fresh bits available
rnd_ready_o  output  1  controller consumes fresh word this cycle when rnd_valid_i=1
fresh_ld_o  output  1  load the external 32-bit fresh register feeding the core Fresh input
core_en_o  output  1  clock-enable for the core's gadget registers
state_en_o  output  1  shift the masked state by 32 and insert both core output shares
busy_o  output  1  permutation in progress
done_o  output  1  single-cycle completion pulse
round_o  output  CNT_W  index of current frame

Behaviour:
- Reset (rst=0 at a clock edge) forces IDLE. All outputs are 0 from the next cycle. round counter=0, latency counter=0, stored long flag=0.
- States: IDLE, REQ, WAIT, SHIFT, DONE. All outputs are registered-state decoded: Moore, except rnd_ready_o and fresh_ld_o.
- IDLE: busy_o=0. If start_i=1: latch long_i, round=0, go to REQ.
- REQ: busy_o=1, rnd_ready_o=1. If rnd_valid_i=1: fresh_ld_o=1 (same cycle, fresh_ld_o = rnd_ready_o & rnd_valid_i), lat_cnt=0, go to WAIT. Otherwise stay in REQ with no timeout; core and state remain frozen.
- WAIT: core_en_o=1, busy_o=1. lat_cnt increments each cycle. When lat_cnt==NLFSR_LAT-1, go to SHIFT. The fresh register must not reload in WAIT: rnd_ready_o=0.
- SHIFT: state_en_o=1 for exactly one cycle, busy_o=1.
  - If round==target-1 (target = ROUNDS_LONG if latched long else ROUNDS_SHORT): go to DONE.
  - Else round+=1 and go to REQ.
- DONE: done_o=1, busy_o=1 for one cycle. round resets to 0. Go to IDLE.
- Per-frame cost with rnd_valid_i held high: NLFSR_LAT+2 cycles.
- Start accepted at cycle 0 → done_o high at cycle R*(NLFSR_LAT+2)+1.
- start_i while not IDLE is ignored. A long_i change mid-run has no effect.
- start_i in the same cycle as done_o is ignored; it is accepted the next cycle in IDLE, so there is a minimum 1 idle cycle between runs.
- Reset mid-run aborts immediately. No state_en_o or done_o follows, and the external state content is undefined.
- round_o holds its value in IDLE (0 after DONE).

Optional Feature:
Macro TJ_PERM_CTRL_ABORT_EN.
- Defined: adds input abort_i (1 bit). abort_i=1 in REQ or WAIT → next state IDLE, with no state_en_o and no done_o.
  - Adds output aborted_o, a single-cycle pulse on the IDLE-entry cycle.
  - abort_i in SHIFT is ignored (the shift completes), and the abort is honoured in the following REQ.
  - abort_i in IDLE/DONE is ignored.
- Not defined: neither port exists, and behaviour is exactly as above.

Test Plan:
- rnd_valid_i=1 constant, start_i pulse with long_i=0, NLFSR_LAT=2 → 20 state_en_o pulses spaced 4 cycles apart, done_o at cycle 81, busy_o high cycles 1–81.
- Same with long_i=1 → 32 state_en_o pulses, done_o at cycle 129, round_o sequence 0..31.
- rnd_valid_i low for 5 cycles in frame 3 REQ → controller holds REQ, core_en_o=0, no fresh_ld_o; done_o delayed by exactly 5 cycles (86).
- rst=0 asserted during WAIT of frame 10, then released → all outputs 0 next cycle; a fresh start_i completes normally with exactly 20 shifts.
- start_i pulsed during busy and on the done_o cycle → ignored; only one done_o; a start_i held high re-triggers from IDLE the cycle after done_o.
- With TJ_PERM_CTRL_ABORT_EN: abort_i in WAIT of frame 5 → 5 state_en_o pulses total, aborted_o pulse, no done_o; abort_i during SHIFT → 6th shift occurs, abort is taken in the next REQ.
